// File: rtl/uart_link_scheduler_pkg.sv
// Shared definitions for the UART link scheduler and its receive FIFO.
//   BYTE_W      : width of every data byte moved through the scheduler.
//   STROBE_ON/OFF : levels of the active-low uart_wr / uart_oen strobes.
//   state_e     : scheduler FSM states (IDLE, RD, WR, GAP).
package uart_link_scheduler_pkg;

  localparam int BYTE_W = 8;

  localparam logic STROBE_ON  = 1'b0;
  localparam logic STROBE_OFF = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_GAP  = 2'd3
  } state_e;

endpackage

// File: rtl/uart_link_scheduler_rx_fifo.sv
// uart_rx_fifo: synchronous first-word-fall-through byte FIFO.
//   clk, rstn   : clock, asynchronous active-low reset (empties the FIFO).
//   push        : write push_data at the tail this cycle (ignored when full).
//   push_data   : byte to write.
//   pop         : drop the head this cycle (ignored when empty).
//   head        : current head byte, valid whenever level != 0.
//   level       : occupancy, 0..RX_DEPTH.
module uart_rx_fifo
  import uart_link_scheduler_pkg::*;
#(
  parameter int RX_DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push,
  input  logic [BYTE_W-1:0]          push_data,
  input  logic                       pop,
  output logic [BYTE_W-1:0]          head,
  output logic [$clog2(RX_DEPTH):0]  level
);

  localparam int AW = $clog2(RX_DEPTH);

  logic [BYTE_W-1:0] mem_q [RX_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       level_q, level_d;
  logic              do_push, do_pop;

  always_comb begin
    do_push  = push && (level_q != (AW+1)'(RX_DEPTH));
    do_pop   = pop && (level_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    // Depth is a power of two, so the pointers wrap by natural overflow.
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: contents are only visible through level.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign level = level_q;

endmodule

// File: rtl/uart_link_scheduler.sv
// uart_link_scheduler: shares one byte-wide UART core between N_REQ transmit
// requesters and one receive consumer.
//   uart_rxrdy/uart_txrdy/uart_data_rx : status and receive byte from the core.
//   uart_data_tx, uart_wr, uart_oen    : transmit byte and active-low strobes.
//   req_valid/req_data/req_ready       : transmit requesters, byte i at [8i+7:8i].
//   rx_data/rx_valid/rx_ready/rx_level : receive FIFO consumer side (FWFT).
//   grant_id                           : last granted requester.
//   state_dbg                          : current FSM state for observation.
//
// Handshakes: a requester raises req_valid with req_data and holds both until
// it sees req_ready (a one-cycle one-hot pulse coinciding with the uart_wr
// strobe). The consumer pops the FIFO head on any cycle where rx_valid and
// rx_ready are both 1; rx_ready with rx_valid=0 does nothing.
module uart_link_scheduler
  import uart_link_scheduler_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int RX_DEPTH   = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        uart_rxrdy,
  input  logic                        uart_txrdy,
  input  logic [BYTE_W-1:0]           uart_data_rx,
  output logic [BYTE_W-1:0]           uart_data_tx,
  output logic                        uart_wr,
  output logic                        uart_oen,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [BYTE_W*N_REQ-1:0]     req_data,
  output logic [N_REQ-1:0]            req_ready,
  output logic [BYTE_W-1:0]           rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic [$clog2(RX_DEPTH):0]   rx_level,
  output logic [$clog2(N_REQ)-1:0]    grant_id,
  output state_e                      state_dbg
);

  localparam int GID_W = $clog2(N_REQ);
  localparam int LVL_W = $clog2(RX_DEPTH) + 1;
  localparam int CNT_W = $clog2(GAP_CYCLES + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic               wr_q, wr_d;
  logic               oen_q, oen_d;
  logic [BYTE_W-1:0]  data_tx_q, data_tx_d;
  logic [N_REQ-1:0]   req_ready_q, req_ready_d;
  logic [GID_W-1:0]   grant_id_q, grant_id_d;

  logic               rr_found;
  logic [GID_W-1:0]   rr_winner;
  logic [GID_W-1:0]   rr_idx;
  logic               fifo_full;
  logic               fifo_push;
  logic [LVL_W-1:0]   fifo_level;

  // Round-robin search: first requesting index after the last grant.
  always_comb begin
    rr_found  = 1'b0;
    rr_winner = grant_id_q;
    rr_idx    = grant_id_q;
    for (int k = 1; k <= N_REQ; k++) begin
      rr_idx = GID_W'((int'(grant_id_q) + k) % N_REQ);
      if (!rr_found && req_valid[rr_idx]) begin
        rr_found  = 1'b1;
        rr_winner = rr_idx;
      end
    end
  end

  assign fifo_full = (fifo_level == LVL_W'(RX_DEPTH));

  // Strobes and req_ready are computed for the state being entered, so the
  // registered outputs are low exactly while state_q is RD or WR.
  always_comb begin
    state_d     = state_q;
    gap_cnt_d   = gap_cnt_q;
    wr_d        = STROBE_OFF;
    oen_d       = STROBE_OFF;
    data_tx_d   = data_tx_q;
    req_ready_d = '0;
    grant_id_d  = grant_id_q;
    case (state_q)
      ST_IDLE: begin
        // Receive wins; a full FIFO leaves the byte in the core and lets
        // transmit use this cycle instead.
        if (uart_rxrdy && !fifo_full) begin
          state_d = ST_RD;
          oen_d   = STROBE_ON;
        end else if (uart_txrdy && rr_found) begin
          state_d                = ST_WR;
          wr_d                   = STROBE_ON;
          data_tx_d              = req_data[int'(rr_winner)*BYTE_W +: BYTE_W];
          grant_id_d             = rr_winner;
          req_ready_d[rr_winner] = 1'b1;
        end
      end
      ST_RD, ST_WR: begin
        state_d   = ST_GAP;
        gap_cnt_d = CNT_W'(GAP_CYCLES - 1);
      end
      ST_GAP: begin
        if (gap_cnt_q == '0) state_d = ST_IDLE;
        else                 gap_cnt_d = gap_cnt_q - CNT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      gap_cnt_q   <= '0;
      wr_q        <= STROBE_OFF;
      oen_q       <= STROBE_OFF;
      data_tx_q   <= '0;
      req_ready_q <= '0;
      grant_id_q  <= GID_W'(N_REQ - 1);
    end else begin
      state_q     <= state_d;
      gap_cnt_q   <= gap_cnt_d;
      wr_q        <= wr_d;
      oen_q       <= oen_d;
      data_tx_q   <= data_tx_d;
      req_ready_q <= req_ready_d;
      grant_id_q  <= grant_id_d;
    end
  end

  // The core's receive byte is captured at the end of the RD cycle.
  assign fifo_push = (state_q == ST_RD);

  uart_rx_fifo #(
    .RX_DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (fifo_push),
    .push_data (uart_data_rx),
    .pop       (rx_ready),
    .head      (rx_data),
    .level     (fifo_level)
  );

  assign rx_valid     = (fifo_level != '0);
  assign rx_level     = fifo_level;
  assign uart_wr      = wr_q;
  assign uart_oen     = oen_q;
  assign uart_data_tx = data_tx_q;
  assign req_ready    = req_ready_q;
  assign grant_id     = grant_id_q;
  assign state_dbg    = state_q;

endmodule

// File: doc/uart_link_scheduler.md
Name: uart_link_scheduler

Overview:
- Sequences a single shared byte-wide UART core between N_REQ transmit requesters and one receive consumer.
- Drives the core's active-low write strobe (wr) and read-enable strobe (oen) from its txrdy/rxrdy status flags.
- Arbitrates transmit requests round-robin and buffers received bytes in a small FIFO.
- Sits between the UART core and the application-side protocol engines.

Parameters:
- N_REQ, 4, number of transmit requesters (2..8).
- RX_DEPTH, 8, receive FIFO depth in bytes (power of 2, 2..64).
- GAP_CYCLES, 1, cycles both strobes are held high after each strobe, before the status flags are re-sampled (1..4).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rstn  in  1  asynchronous active-low reset.
- uart_rxrdy  in  1  core holds a received byte.
- uart_txrdy  in  1  core can accept a byte.
- uart_data_rx  in  8  received byte, valid while uart_rxrdy=1.
- uart_data_tx  out  8  byte to transmit.
- uart_wr  out  1  active-low write strobe.
- uart_oen  out  1  active-low read strobe.
- req_valid  in  N_REQ  per-requester transmit request.
- req_data  in  8*N_REQ  byte i at bits [8i+7:8i].
- req_ready  out  N_REQ  one-hot accept pulse.
- rx_data  out  8  FIFO head byte (first-word-fall-through).
- rx_valid  out  1  FIFO not empty.
- rx_ready  in  1  consumer pops the head when rx_valid=1.
- rx_level  out  clog2(RX_DEPTH)+1  FIFO occupancy.
- grant_id  out  clog2(N_REQ)  last granted requester.

Behaviour:
- Reset, asynchronous, all outputs take these values immediately:
  - uart_wr=1, uart_oen=1, uart_data_tx=0.
  - req_ready=0, FIFO emptied (rx_valid=0, rx_level=0).
  - grant_id=N_REQ-1, so requester 0 wins first.
  - FSM goes to IDLE; any strobe in progress is aborted and any latched byte is discarded.
- All outputs are registered, except rx_data and rx_valid, which come straight from the FIFO storage and level.
- FSM states: IDLE, RD, WR, GAP.
- IDLE:
  - If uart_rxrdy=1 and rx_level<RX_DEPTH: go to RD. Receive has priority over transmit.
  - Else if uart_txrdy=1 and any req_valid: pick winner w, the first set bit searching from grant_id+1 modulo N_REQ. Latch uart_data_tx<=req_data[w], grant_id<=w, go to WR.
  - Else stay in IDLE.
- RD, 1 cycle:
  - uart_oen=0.
  - uart_data_rx is written to the FIFO at the end of this cycle.
  - Next state GAP.
- WR, 1 cycle:
  - uart_wr=0 and req_ready[grant_id]=1.
  - Requesters hold req_valid and req_data stable until req_ready; the byte was already latched on entry to WR.
  - Next state GAP.
- GAP:
  - Both strobes are 1 for GAP_CYCLES cycles (down-counter), then the FSM returns to IDLE.
  - A full transaction therefore takes 2+GAP_CYCLES cycles, IDLE cycle included.
- Strobes are never low together, and each is low for exactly one cycle per transaction.
- FIFO full in IDLE with uart_rxrdy=1: the byte stays in the core (no read, no loss in this block), and transmit may proceed in that IDLE cycle.
- FIFO push (RD) and pop (rx_ready & rx_valid) in the same cycle: both take effect and rx_level is unchanged.
- A pop with rx_valid=0 is ignored.
- Pointers wrap modulo RX_DEPTH.
- A requester dropping req_valid before req_ready violates the protocol. The scheduler still transmits the byte it latched.

Decomposition:
- Shared package:
  - FSM state enum (IDLE/RD/WR/GAP).
  - STROBE_ON=1'b0 and STROBE_OFF=1'b1 constants.
  - Byte width constant 8.
- One sub-module, uart_rx_fifo:
  - Synchronous first-word-fall-through FIFO, parameter RX_DEPTH.
  - Ports: push, push_data, pop, head, level.
- Round-robin search stays inline in the scheduler.

Test Plan:
- Reset then uart_txrdy=1, req_valid=4'b0001, req_data[7:0]=8'hA5 -> uart_data_tx=8'hA5, uart_wr low exactly 1 cycle, req_ready=4'b0001 in the same cycle, grant_id=0.
- req_valid=4'b1111 held with uart_txrdy=1 -> grant order 0,1,2,3,0, and successive uart_wr pulses 3 cycles apart (GAP_CYCLES=1).
- uart_rxrdy=1 and uart_txrdy=1 with req_valid=4'b0010 in the same IDLE cycle -> uart_oen pulses first and the 8'h3C receive byte is pushed; the uart_wr pulse follows 3 cycles later.
- Push 8 bytes 8'h01..8'h08 with rx_ready=0, then a 9th rxrdy -> rx_level=8, no further uart_oen pulse; pop once -> the 9th byte is read and rx_data order is 01..08 then 09.
- Push and pop in the same cycle at rx_level=3 -> rx_level stays 3.
- rstn low during WR -> uart_wr=1, req_ready=0, rx_level=0 immediately; after release, requester 0 is granted first.
